// File: rtl/parking_gate_scheduler_pkg.sv
// Shared types and default constants for the parking gate scheduler.
// Contents:
//   DEF_NUM_SLOTS / DEF_ID_W - default slot count and slot ID width
//   sched_state_e            - scheduler FSM states
//   gate_sel_e               - which gate a hold phase drives (also the arbiter priority value)
package parking_pkg;

    localparam int DEF_NUM_SLOTS = 4;
    localparam int DEF_ID_W      = 2;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY_WR,
        EXIT_RD,
        EXIT_DONE,
        GATE_HOLD
    } sched_state_e;

    typedef enum logic {
        GATE_ENTRY,
        GATE_EXIT
    } gate_sel_e;

endpackage

// File: rtl/parking_gate_scheduler_if.sv
// Request/acknowledge and timestamp-buffer signals of the parking gate scheduler.
//   master : gate detector side (drives requests, observes acks and buffer strobes)
//   slave  : scheduler side
// Signals: entry_req, exit_req, exit_id, entry_ack, entry_slot, exit_ack, exit_err,
//          buf_write, buf_read, buf_id.
interface parking_gate_scheduler_if #(
    parameter int ID_W = 2
) ();
    logic            entry_req;
    logic            exit_req;
    logic [ID_W-1:0] exit_id;
    logic            entry_ack;
    logic [ID_W-1:0] entry_slot;
    logic            exit_ack;
    logic            exit_err;
    logic            buf_write;
    logic            buf_read;
    logic [ID_W-1:0] buf_id;

    modport master (
        output entry_req, exit_req, exit_id,
        input  entry_ack, entry_slot, exit_ack, exit_err, buf_write, buf_read, buf_id
    );

    modport slave (
        input  entry_req, exit_req, exit_id,
        output entry_ack, entry_slot, exit_ack, exit_err, buf_write, buf_read, buf_id
    );
endinterface

// File: rtl/parking_gate_scheduler_slot_allocator.sv
// Occupancy register with lowest-free-slot encoder and registered full/empty flags.
// Ports:
//   clk, reset          - clock, synchronous active-low reset
//   set_en / set_id     - mark a slot occupied at the end of the cycle
//   clr_en / clr_id     - mark a slot free at the end of the cycle
//   occupancy           - one bit per slot
//   free_id             - lowest-index free slot (0 when none is free)
//   full_flag/empty_flag- registered, follow occupancy by one cycle
module slot_allocator #(
    parameter int NUM_SLOTS = 4,
    parameter int ID_W      = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set_en,
    input  logic [ID_W-1:0]      set_id,
    input  logic                 clr_en,
    input  logic [ID_W-1:0]      clr_id,
    output logic [NUM_SLOTS-1:0] occupancy,
    output logic [ID_W-1:0]      free_id,
    output logic                 full_flag,
    output logic                 empty_flag
);
    logic [NUM_SLOTS-1:0] occ_q, occ_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;

    always_comb begin
        occ_d = occ_q;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (set_en && set_id == ID_W'(i)) occ_d[i] = 1'b1;
            if (clr_en && clr_id == ID_W'(i)) occ_d[i] = 1'b0;
        end
        // Flags are derived from the registered occupancy, so they lag it by a cycle.
        full_d  = &occ_q;
        empty_d = ~|occ_q;
    end

    // Descending scan so the lowest free index is the one that sticks.
    always_comb begin
        free_id = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!occ_q[i]) free_id = ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    assign occupancy  = occ_q;
    assign full_flag  = full_q;
    assign empty_flag = empty_q;
endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises entry/exit gate requests onto the single timestamp buffer port,
// allocates/validates slot IDs and holds the served gate open for a fixed time.
// Optional build macro ROUND_ROBIN_EN: alternate tie priority after every grant;
// when undefined exits always win a tie and no pointer register exists.
// Ports:
//   clk, reset                      - clock, synchronous active-low reset
//   sched_bus (slave)               - requests, acks, buffer strobes and index
//   gate_entry_open, gate_exit_open - gate actuators
//   occupancy, full_flag, empty_flag- slot status
//
// state     | meaning
// IDLE      | sample and arbitrate requests
// ENTRY_WR  | write timestamp for lowest free slot, pulse entry_ack
// EXIT_RD   | validate latched ID; read buffer or pulse exit_err
// EXIT_DONE | buffer data registered, pulse exit_ack
// GATE_HOLD | selected gate open for GATE_OPEN_CYCLES cycles
module parking_gate_scheduler
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS        = DEF_NUM_SLOTS,
    parameter int ID_W             = DEF_ID_W,
    parameter int GATE_OPEN_CYCLES = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    parking_gate_scheduler_if.slave  sched_bus,
    output logic                     gate_entry_open,
    output logic                     gate_exit_open,
    output logic [NUM_SLOTS-1:0]     occupancy,
    output logic                     full_flag,
    output logic                     empty_flag
);
    localparam logic [7:0] HOLD_LOAD = 8'(GATE_OPEN_CYCLES - 1);

    sched_state_e    state_q, state_d;
    logic [ID_W-1:0] exit_id_q, exit_id_d;
    logic [7:0]      hold_cnt_q, hold_cnt_d;
    gate_sel_e       gate_sel_q, gate_sel_d;
    gate_sel_e       prio_cur;

    logic            entry_ok, exit_ok, grant_exit, exit_valid;
    logic            set_en, clr_en;
    logic [ID_W-1:0] free_id;

    slot_allocator #(
        .NUM_SLOTS (NUM_SLOTS),
        .ID_W      (ID_W)
    ) u_slot_allocator (
        .clk        (clk),
        .reset      (reset),
        .set_en     (set_en),
        .set_id     (free_id),
        .clr_en     (clr_en),
        .clr_id     (exit_id_q),
        .occupancy  (occupancy),
        .free_id    (free_id),
        .full_flag  (full_flag),
        .empty_flag (empty_flag)
    );

    assign entry_ok   = sched_bus.entry_req && !full_flag;
    assign exit_ok    = sched_bus.exit_req;
    assign grant_exit = exit_ok && (!entry_ok || prio_cur == GATE_EXIT);

`ifdef ROUND_ROBIN_EN
    gate_sel_e prio_q, prio_d;

    always_comb begin
        prio_d = prio_q;
        if (state_q == IDLE && (entry_ok || exit_ok))
            prio_d = (prio_q == GATE_EXIT) ? GATE_ENTRY : GATE_EXIT;
    end

    always_ff @(posedge clk) begin
        if (!reset) prio_q <= GATE_EXIT;
        else        prio_q <= prio_d;
    end

    assign prio_cur = prio_q;
`else
    assign prio_cur = GATE_EXIT;
`endif

    // IDs outside the slot range never match a slot, so they read as unoccupied.
    always_comb begin
        exit_valid = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (exit_id_q == ID_W'(i) && occupancy[i]) exit_valid = 1'b1;
        end
    end

    always_comb begin
        state_d              = state_q;
        exit_id_d            = exit_id_q;
        hold_cnt_d           = hold_cnt_q;
        gate_sel_d           = gate_sel_q;
        set_en               = 1'b0;
        clr_en               = 1'b0;
        sched_bus.entry_ack  = 1'b0;
        sched_bus.entry_slot = '0;
        sched_bus.exit_ack   = 1'b0;
        sched_bus.exit_err   = 1'b0;
        sched_bus.buf_write  = 1'b0;
        sched_bus.buf_read   = 1'b0;
        sched_bus.buf_id     = '0;
        gate_entry_open      = 1'b0;
        gate_exit_open       = 1'b0;

        case (state_q)
            IDLE: begin
                if (grant_exit) begin
                    state_d   = EXIT_RD;
                    exit_id_d = sched_bus.exit_id;
                end else if (entry_ok) begin
                    state_d = ENTRY_WR;
                end
            end
            ENTRY_WR: begin
                sched_bus.buf_write  = 1'b1;
                sched_bus.buf_id     = free_id;
                sched_bus.entry_slot = free_id;
                sched_bus.entry_ack  = 1'b1;
                set_en               = 1'b1;
                gate_sel_d           = GATE_ENTRY;
                hold_cnt_d           = HOLD_LOAD;
                state_d              = GATE_HOLD;
            end
            EXIT_RD: begin
                if (exit_valid) begin
                    sched_bus.buf_read = 1'b1;
                    sched_bus.buf_id   = exit_id_q;
                    clr_en             = 1'b1;
                    state_d            = EXIT_DONE;
                end else begin
                    sched_bus.exit_err = 1'b1;
                    state_d            = IDLE;
                end
            end
            EXIT_DONE: begin
                sched_bus.exit_ack = 1'b1;
                gate_sel_d         = GATE_EXIT;
                hold_cnt_d         = HOLD_LOAD;
                state_d            = GATE_HOLD;
            end
            GATE_HOLD: begin
                gate_entry_open = (gate_sel_q == GATE_ENTRY);
                gate_exit_open  = (gate_sel_q == GATE_EXIT);
                if (hold_cnt_q == 8'd0) state_d = IDLE;
                else                    hold_cnt_d = hold_cnt_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            exit_id_q  <= '0;
            hold_cnt_q <= 8'd0;
            gate_sel_q <= GATE_ENTRY;
        end else begin
            state_q    <= state_d;
            exit_id_q  <= exit_id_d;
            hold_cnt_q <= hold_cnt_d;
            gate_sel_q <= gate_sel_d;
        end
    end
endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
- Sequencer and arbiter for the garage's shared timestamp buffer and its entry/exit gates.
- Accepts entry and exit requests from the gate detectors and serialises them onto the single buffer write/read port.
- Allocates a free car slot ID on entry, validates the slot ID on exit, and holds the corresponding gate open for a fixed time.
- Sits between the entry/exit detection logic and the timestamp buffer / cost path.

Parameters:
- NUM_SLOTS, 4, number of parking slots; one occupancy bit per slot.
- ID_W, 2, slot ID width; must satisfy 2**ID_W >= NUM_SLOTS.
- GATE_OPEN_CYCLES, 8, cycles a gate stays open after a served request; legal range 1..255.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- entry_req  in  1  level request from the entry gate.
- exit_req  in  1  level request from the exit gate.
- exit_id  in  ID_W  slot ID presented with exit_req.
- entry_ack  out  1  one-cycle pulse; entry_slot is valid in that cycle.
- entry_slot  out  ID_W  allocated slot ID.
- exit_ack  out  1  one-cycle pulse; exit served and cost data valid downstream.
- exit_err  out  1  one-cycle pulse; exit_id was not occupied.
- buf_write  out  1  timestamp buffer write strobe.
- buf_read  out  1  timestamp buffer read strobe.
- buf_id  out  ID_W  buffer index.
- gate_entry_open  out  1  entry gate actuator.
- gate_exit_open  out  1  exit gate actuator.
- occupancy  out  NUM_SLOTS  bit i set means slot i is occupied.
- full_flag  out  1  all slots occupied.
- empty_flag  out  1  no slot occupied.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE, occupancy=0, hold counter=0, priority pointer=EXIT.
  - All pulses, strobes and gate outputs are 0; buf_id=0; entry_slot=0.
  - empty_flag=1, full_flag=0.
  - Reset mid-operation aborts any operation: no ack is issued and occupancy is cleared.
- FSM states: IDLE, ENTRY_WR, EXIT_RD, EXIT_DONE, GATE_HOLD.
- Requests are sampled only in IDLE. Eligibility:
  - An entry is eligible iff entry_req and !full_flag.
  - An exit is eligible iff exit_req.
- Arbitration in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant per the priority pointer; the pointer toggles after every grant when ROUND_ROBIN_EN is defined.
  - Neither: stay in IDLE.
- Entry path:
  - IDLE -> ENTRY_WR. In ENTRY_WR (one cycle): buf_write=1, buf_id = lowest-index free slot, entry_slot = same value, entry_ack=1. The occupancy bit is set at the end of that cycle.
  - ENTRY_WR -> GATE_HOLD with gate_entry_open=1.
  - Latency from request sample to entry_ack: 1 cycle.
- Exit path:
  - IDLE -> EXIT_RD, with exit_id latched at the grant.
  - If occupancy[exit_id]==1: buf_read=1, buf_id=latched ID, and the occupancy bit is cleared at the end of the cycle. Then -> EXIT_DONE, where exit_ack=1 for one cycle (buffer data is registered), then -> GATE_HOLD with gate_exit_open=1.
  - If occupancy[exit_id]==0, or exit_id >= NUM_SLOTS: no buf_read, exit_err=1 in EXIT_RD, return to IDLE, gate stays closed.
- GATE_HOLD:
  - Counts GATE_OPEN_CYCLES cycles with the selected gate output high.
  - Returns to IDLE; the gate output drops in the cycle IDLE is entered.
  - Requesters must drop their req before the hold ends. A req still high in IDLE is treated as a new request.
- Flags:
  - full_flag and empty_flag are registered and derived from occupancy; they update the cycle after the occupancy change.
  - An entry request while full is held off indefinitely: no ack, no error. It becomes eligible once an exit frees a slot.
- Simultaneous requests with full==1: the exit is served, then the entry is served in the next IDLE visit.
- buf_write and buf_read are never high in the same cycle. Exactly one strobe per served request.

Optional Feature:
- ROUND_ROBIN_EN
  - Defined: the priority pointer alternates EXIT/ENTRY after each grant, giving fair service under continuous contention.
  - Undefined: fixed priority, exit always wins a tie, and the pointer register is not implemented.

Decomposition:
- Shared package parking_pkg holds:
  - the FSM state enum (IDLE, ENTRY_WR, EXIT_RD, EXIT_DONE, GATE_HOLD);
  - default constants NUM_SLOTS=4, ID_W=2;
  - a gate-select enum (GATE_ENTRY, GATE_EXIT).
- One sub-module, slot_allocator:
  - owns the occupancy register, set/clear ports, lowest-free-slot priority encoder, and registered full/empty flags.
  - The scheduler FSM and arbiter stay in parking_gate_scheduler.

Test Plan:
1. Reset low 2 cycles, then entry_req=1 -> entry_ack 1 cycle later with entry_slot=0, buf_write=1 with buf_id=0, occupancy=0001, gate_entry_open high for exactly 8 cycles.
2. Four sequential entries -> slots 0,1,2,3 allocated, full_flag=1. A fifth entry_req held 20 cycles -> no ack, no buf_write.
3. Occupancy=0101, exit_req with exit_id=2 -> buf_read with buf_id=2, exit_ack 1 cycle after buf_read, occupancy=0001, gate_exit_open high for 8 cycles.
4. exit_req with exit_id=3 while occupancy=0001 -> exit_err pulse, no buf_read, no gate opening, FSM back in IDLE next cycle.
5. Full garage, entry_req and exit_id=1 requested in the same cycle -> exit served first. After the hold, the entry is acked with entry_slot=1. With ROUND_ROBIN_EN and both requests held continuously, grants alternate exit, entry, exit.
6. Reset asserted during GATE_HOLD and during EXIT_DONE -> the next cycle has all outputs 0, occupancy=0, empty_flag=1, and no exit_ack is emitted.
